// File: rtl/multicycle_control.sv
// Multi-cycle FSM controller for a MIPS subset running on a shared single-ALU datapath.
// Optional memory handshake stalls in FETCH/MEM are enabled by defining MC_CONTROL_STALL_EN.
module multicycle_control #(
    parameter int               CMD_W   = 3,
    parameter logic [CMD_W-1:0] CMD_ADD = 3'b000,
    parameter logic [CMD_W-1:0] CMD_SUB = 3'b001,
    parameter logic [CMD_W-1:0] CMD_XOR = 3'b010,
    parameter logic [CMD_W-1:0] CMD_SLT = 3'b011
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
`ifdef MC_CONTROL_STALL_EN
    input  logic             mem_ready,
`endif
    output logic             pc_write,
    output logic [1:0]       pc_source,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [CMD_W-1:0] alu_command,
    output logic             illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic       mem_rdy;

`ifdef MC_CONTROL_STALL_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   is_legal = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h2A) || (fn == 6'h08);
            6'h08, 6'h0E, 6'h23, 6'h2B, 6'h05, 6'h02, 6'h03: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

    // Instruction classes come only from the opcode/funct latched in DECODE.
    logic is_r, is_jr, is_addi, is_xori, is_lw, is_sw, is_bne, is_j, is_jal;
    assign is_jr   = (op_q == 6'h00) && (fn_q == 6'h08);
    assign is_r    = (op_q == 6'h00) && !is_jr;
    assign is_addi = (op_q == 6'h08);
    assign is_xori = (op_q == 6'h0E);
    assign is_lw   = (op_q == 6'h23);
    assign is_sw   = (op_q == 6'h2B);
    assign is_bne  = (op_q == 6'h05);
    assign is_j    = (op_q == 6'h02);
    assign is_jal  = (op_q == 6'h03);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= 6'h00;
            fn_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                op_d    = opcode;
                fn_d    = funct;
                state_d = is_legal(opcode, funct) ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                if (is_r || is_addi || is_xori) state_d = S_WB;
                else if (is_lw || is_sw)        state_d = S_MEM;
                else                            state_d = S_FETCH;
            end
            S_MEM:    if (mem_rdy) state_d = is_lw ? S_WB : S_FETCH;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        pc_source   = 2'd0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_command = CMD_ADD;
        illegal_op  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
                alu_src_b = 2'd1;
            end
            S_DECODE: begin
                alu_src_b  = 2'd3;
                illegal_op = !is_legal(opcode, funct);
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_src_a = 1'b1;
                    case (fn_q)
                        6'h22:   alu_command = CMD_SUB;
                        6'h2A:   alu_command = CMD_SLT;
                        default: alu_command = CMD_ADD;
                    endcase
                end else if (is_addi || is_xori || is_lw || is_sw) begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'd2;
                    alu_command = is_xori ? CMD_XOR : CMD_ADD;
                end else if (is_bne) begin
                    alu_src_a   = 1'b1;
                    alu_command = CMD_SUB;
                    pc_write    = !zero;
                    pc_source   = zero ? 2'd0 : 2'd1;
                end else if (is_j || is_jal) begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                    if (is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_write  = 1'b1;
                    pc_source = 2'd3;
                end
            end
            S_MEM: begin
                mem_read  = is_lw;
                mem_write = is_sw;
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r ? 2'd1 : 2'd0;
                mem_to_reg = is_lw ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
    end

endmodule
